alu_share_arbiter: RTL and testbench

Shares the single-cycle combinational RISC-V ALU between two requesters (port 0: integer execute path, port 1: address/branch-compare path). Accepts one operation at a time over a valid/ready request handshake, arbitrates round-robin, registers operands onto the ALU for a fixed number of cycles, captures the result and zero flag, and returns them on a per-port valid/ready response channel. Sits between the requesters and the ALU instance; the ALU itself is unchanged.

---
 rtl/alu_share_arbiter_pkg.sv | 18 +
 rtl/alu_share_arbiter_rr_arb2.sv | 13 +
 rtl/alu_share_arbiter.sv | 112 +++++++++++
 tb/tb_alu_share_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the two-port ALU sharing arbiter: ALU control codes,
// FSM state encodings and the default datapath width.
package alu_share_arbiter_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-input round-robin grant: on contention the pointer picks the winner,
// otherwise the lone requester wins.
module alu_share_arbiter_rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_prio,
    output logic       o_vld,
    output logic       o_grant
);

    assign o_vld   = |i_req;
    assign o_grant = (&i_req) ? i_prio : i_req[1];

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between two requesters: round-robin accept,
// hold operands on the ALU for ALU_LAT cycles, then return result/zero to the owner.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_0,
    output logic             req_ready_0,
    input  logic [3:0]       req_ctl_0,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_b_0,
    input  logic             req_valid_1,
    output logic             req_ready_1,
    input  logic [3:0]       req_ctl_1,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_1,
    output logic             rsp_valid_0,
    input  logic             rsp_ready_0,
    output logic [WIDTH-1:0] rsp_result_0,
    output logic             rsp_zero_0,
    output logic             rsp_valid_1,
    input  logic             rsp_ready_1,
    output logic [WIDTH-1:0] rsp_result_1,
    output logic             rsp_zero_1,
    output logic [3:0]       alu_ctl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    logic [1:0]       r_state;
    logic             r_prio;
    logic             r_owner;
    logic [3:0]       r_ctl;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [CW-1:0]    r_cnt;

    logic w_gvld;
    logic w_grant;
    logic w_accept;
    logic w_rsp_take;

    alu_share_arbiter_rr_arb2 u_arb (
        .i_req   ({req_valid_1, req_valid_0}),
        .i_prio  (r_prio),
        .o_vld   (w_gvld),
        .o_grant (w_grant)
    );

    // rst_n gates ready so nothing looks accepted while reset is asserted
    assign w_accept    = rst_n && (r_state == ST_IDLE) && w_gvld;
    assign req_ready_0 = w_accept && !w_grant;
    assign req_ready_1 = w_accept &&  w_grant;
    assign w_rsp_take  = r_owner ? rsp_ready_1 : rsp_ready_0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_prio   <= 1'b0;
            r_owner  <= 1'b0;
            r_ctl    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_ctl   <= w_grant ? req_ctl_1 : req_ctl_0;
                    r_a     <= w_grant ? req_a_1   : req_a_0;
                    r_b     <= w_grant ? req_b_1   : req_b_0;
                    r_owner <= w_grant;
                    r_prio  <= !w_grant;
                    r_cnt   <= CW'(ALU_LAT - 1);
                    r_state <= ST_EXEC;
                end
                ST_EXEC: if (r_cnt == '0) begin
                    r_result <= alu_out;
                    r_zero   <= (alu_out == '0);
                    r_state  <= ST_RESP;
                end else begin
                    r_cnt <= r_cnt - CW'(1);
                end
                ST_RESP: if (w_rsp_take) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid_0  = (r_state == ST_RESP) && !r_owner;
    assign rsp_valid_1  = (r_state == ST_RESP) &&  r_owner;
    assign rsp_result_0 = r_result;
    assign rsp_result_1 = r_result;
    assign rsp_zero_0   = r_zero;
    assign rsp_zero_1   = r_zero;

    // ALU inputs only change on accept, so they stay quiet outside EXEC
    assign alu_ctl = r_ctl;
    assign alu_a   = r_a;
    assign alu_b   = r_b;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: instance 0 with ALU_LAT=1, instance 1 with ALU_LAT=3,
// directed scenarios then randomized traffic against a transaction-level model.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        rqv   [2][2];
    logic        rqr   [2][2];
    logic [3:0]  rqc   [2][2];
    logic [31:0] rqa   [2][2];
    logic [31:0] rqb   [2][2];
    logic        rsv   [2][2];
    logic        rsr   [2][2];
    logic [31:0] rsres [2][2];
    logic        rsz   [2][2];
    logic [3:0]  actl  [2];
    logic [31:0] aa    [2];
    logic [31:0] ab    [2];
    logic [31:0] aout  [2];

    int n_tests = 0;
    int n_fail  = 0;
    int prio_m [2];

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        alu_share_arbiter #(.WIDTH(32), .ALU_LAT(k == 0 ? 1 : 3)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n[k]),
            .req_valid_0  (rqv[k][0]),
            .req_ready_0  (rqr[k][0]),
            .req_ctl_0    (rqc[k][0]),
            .req_a_0      (rqa[k][0]),
            .req_b_0      (rqb[k][0]),
            .req_valid_1  (rqv[k][1]),
            .req_ready_1  (rqr[k][1]),
            .req_ctl_1    (rqc[k][1]),
            .req_a_1      (rqa[k][1]),
            .req_b_1      (rqb[k][1]),
            .rsp_valid_0  (rsv[k][0]),
            .rsp_ready_0  (rsr[k][0]),
            .rsp_result_0 (rsres[k][0]),
            .rsp_zero_0   (rsz[k][0]),
            .rsp_valid_1  (rsv[k][1]),
            .rsp_ready_1  (rsr[k][1]),
            .rsp_result_1 (rsres[k][1]),
            .rsp_zero_1   (rsz[k][1]),
            .alu_ctl      (actl[k]),
            .alu_a        (aa[k]),
            .alu_b        (ab[k]),
            .alu_out      (aout[k])
        );
        assign aout[k] = alu_ref(actl[k], aa[k], ab[k]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int k, input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        rqv[k][p] = 1'b1;
        rqc[k][p] = c;
        rqa[k][p] = a;
        rqb[k][p] = b;
    endtask

    // Entered just after inputs are set in an IDLE cycle; returns at negedge+1 of the next IDLE cycle.
    task automatic serve(input int k, input int w, input logic [31:0] er, input logic ez, input int hold);
        logic [3:0]  c;
        logic [31:0] a, b;
        int lat;
        lat = (k == 0) ? 1 : 3;
        chk("req_ready_winner", rqr[k][w], 1'b1);
        chk("req_ready_loser", rqr[k][1-w], 1'b0);
        c = rqc[k][w]; a = rqa[k][w]; b = rqb[k][w];
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            if (i == 1) rqv[k][w] = 1'b0;
            #1;
            chk("exec_rsp_valid", {rsv[k][0], rsv[k][1]}, 2'b00);
            chk("exec_req_ready", {rqr[k][0], rqr[k][1]}, 2'b00);
            chk("exec_alu_ctl", actl[k], c);
            chk("exec_alu_a", aa[k], a);
            chk("exec_alu_b", ab[k], b);
        end
        for (int j = 0; j <= hold; j++) begin
            @(negedge clk);
            rsr[k][w]   = (j == hold);
            rsr[k][1-w] = 1'($urandom_range(0, 1));
            #1;
            chk("rsp_valid_owner", rsv[k][w], 1'b1);
            chk("rsp_valid_other", rsv[k][1-w], 1'b0);
            chk("rsp_result", rsres[k][w], er);
            chk("rsp_zero", rsz[k][w], ez);
            chk("resp_req_ready", {rqr[k][0], rqr[k][1]}, 2'b00);
        end
        @(negedge clk);
        rsr[k][0] = 1'b0;
        rsr[k][1] = 1'b0;
        #1;
        chk("idle_rsp_valid", {rsv[k][0], rsv[k][1]}, 2'b00);
        prio_m[k] = 1 - w;
    endtask

    task automatic serve_next(input int k);
        int w;
        logic [31:0] r;
        #1;
        w = (rqv[k][0] && rqv[k][1]) ? prio_m[k] : (rqv[k][0] ? 0 : 1);
        r = alu_ref(rqc[k][w], rqa[k][w], rqb[k][w]);
        serve(k, w, r, (r == 32'd0), $urandom_range(0, 3));
    endtask

    task automatic rand_run(input int k, input int n);
        logic [3:0]  ops [7] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, 4'd5};
        logic [31:0] a, b;
        for (int it = 0; it < n; it++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rqv[k][p] && $urandom_range(0, 2) != 0) begin
                    a = $urandom;
                    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                    req(k, p, ops[$urandom_range(0, 6)], a, b);
                end
            end
            if (!rqv[k][0] && !rqv[k][1]) req(k, int'($urandom_range(0, 1)), ALU_ADD, $urandom, $urandom);
            serve_next(k);
        end
        while (rqv[k][0] || rqv[k][1]) serve_next(k);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0;
            prio_m[k] = 0;
            for (int p = 0; p < 2; p++) begin
                rqv[k][p] = 1'b0; rqc[k][p] = '0; rqa[k][p] = '0; rqb[k][p] = '0; rsr[k][p] = 1'b0;
            end
        end

        // Reset state with requests already pending
        @(negedge clk);
        req(0, 0, ALU_SUB, 32'd9, 32'd9);
        req(0, 1, ALU_OR, 32'hF0, 32'h0F);
        req(1, 0, ALU_ADD, 32'd1, 32'd1);
        req(1, 1, ALU_ADD, 32'd2, 32'd2);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_req_ready", {rqr[k][0], rqr[k][1]}, 2'b00);
            chk("rst_rsp_valid", {rsv[k][0], rsv[k][1]}, 2'b00);
            chk("rst_rsp_result", rsres[k][0] | rsres[k][1], 32'd0);
            chk("rst_rsp_zero", {rsz[k][0], rsz[k][1]}, 2'b00);
            chk("rst_alu", {28'd0, actl[k]} | aa[k] | ab[k], 32'd0);
        end
        rqv[1][0] = 1'b0;
        rqv[1][1] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Contention at reset exit: port 0 first, then port 1
        #1; serve(0, 0, 32'd0, 1'b1, 0);
        #1; serve(0, 1, 32'hFF, 1'b0, 0);
        req(0, 0, ALU_AND, 32'hFF, 32'h0F);
        req(0, 1, ALU_ADD, 32'd2, 32'd3);
        #1; serve(0, 0, 32'h0F, 1'b0, 0);
        #1; serve(0, 1, 32'd5, 1'b0, 0);

        // Single port 0 ADD
        req(0, 0, ALU_ADD, 32'd5, 32'd7);
        #1; serve(0, 0, 32'd12, 1'b0, 0);

        // Port 1 wins on prio, response stalled 5 cycles with port 0 pending
        req(0, 0, ALU_ADD, 32'd10, 32'd20);
        req(0, 1, ALU_SLT, 32'd3, 32'd4);
        #1; serve(0, 1, 32'd1, 1'b0, 5);
        #1; serve(0, 0, 32'd30, 1'b0, 0);

        // Undefined control code
        req(0, 0, 4'd5, 32'd1, 32'd1);
        #1; serve(0, 0, 32'd0, 1'b1, 0);

        // Three-cycle ALU hold
        req(1, 0, ALU_AND, 32'hFFFF0000, 32'h0F0F0F0F);
        #1; serve(1, 0, 32'h0F0F0000, 1'b0, 1);

        // Reset during EXEC drops the operation and the pointer
        req(1, 0, ALU_ADD, 32'd1, 32'd2);
        #1;
        chk("pre_rst_accept", rqr[1][0], 1'b1);
        @(negedge clk);
        rqv[1][0] = 1'b0;
        #1;
        rst_n[1] = 1'b0;
        req(1, 0, ALU_ADD, 32'd7, 32'd7);
        req(1, 1, ALU_ADD, 32'd8, 32'd8);
        #1;
        chk("mid_rst_req_ready", {rqr[1][0], rqr[1][1]}, 2'b00);
        chk("mid_rst_rsp_valid", {rsv[1][0], rsv[1][1]}, 2'b00);
        chk("mid_rst_result", rsres[1][0], 32'd0);
        chk("mid_rst_alu", {28'd0, actl[1]} | aa[1] | ab[1], 32'd0);
        rqv[1][0] = 1'b0;
        rqv[1][1] = 1'b0;
        prio_m[1] = 0;
        @(negedge clk);
        rst_n[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            chk("post_rst_no_rsp", {rsv[1][0], rsv[1][1]}, 2'b00);
        end
        req(1, 0, ALU_SUB, 32'd9, 32'd4);
        req(1, 1, ALU_NOR, 32'd0, 32'd0);
        #1; serve(1, 0, 32'd5, 1'b0, 0);
        #1; serve(1, 1, 32'hFFFFFFFF, 1'b0, 0);

        // Randomized traffic
        rand_run(0, 40);
        rand_run(1, 25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
